// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the MEM-stage access sequencer.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned WDOG_W = 8;
  localparam logic [DATA_W-1:0] TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/mem_watchdog.sv
// Saturating wait-cycle counter; flags the cycle in which the count would reach TIMEOUT.
module mem_watchdog
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire_c
);

  localparam int unsigned CMP_W = WDOG_W + 1;
  localparam logic [WDOG_W-1:0] CNT_MAX = '1;

  logic [WDOG_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != CNT_MAX)) begin
      count_d = count_q + WDOG_W'(1);
    end
  end

  // Expire on the wait cycle whose increment brings the count up to TIMEOUT.
  assign expire_c = en && ((CMP_W'(count_q) + CMP_W'(1)) >= CMP_W'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer: runs one word access per instruction against a
// variable-latency memory, stalling the pipeline while it is outstanding.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memtoregm,
  input  logic              memwritem,
  input  logic [DATA_W-1:0] aluoutm,
  input  logic [DATA_W-1:0] writedatam,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] readdatam,
  output logic              stallm,
  output logic              flushw,
  output logic              mem_err
);

  mem_state_e        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] readdata_q, readdata_d;
  logic              mem_err_q, mem_err_d;

  logic access_c, misaligned_c;
  logic wd_clr_c, wd_en_c, wd_expire_c;

  assign access_c     = memtoregm | memwritem;
  assign misaligned_c = access_c && (aluoutm[1:0] != 2'b00);

  mem_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .clr      (wd_clr_c),
    .en       (wd_en_c),
    .expire_c (wd_expire_c)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    readdata_d  = readdata_q;
    mem_err_d   = mem_err_q;
    stallm      = 1'b0;
    wd_clr_c    = 1'b0;
    wd_en_c     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (misaligned_c) begin
          mem_err_d  = 1'b1;
          readdata_d = '0;
        end else if (access_c) begin
          stallm      = 1'b1;
          mem_addr_d  = {aluoutm[DATA_W-1:2], 2'b00};
          mem_wdata_d = writedatam;
          mem_we_d    = memwritem;
          mem_req_d   = 1'b1;
          wd_clr_c    = 1'b1;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        stallm = 1'b1;
        // A completing handshake wins over a timeout in the same cycle.
        if (mem_ready) begin
          if (!mem_we_q) begin
            readdata_d = mem_rdata;
          end
          mem_req_d = 1'b0;
          state_d   = DONE;
        end else begin
          wd_en_c = 1'b1;
          if (wd_expire_c) begin
            mem_err_d  = 1'b1;
            readdata_d = TIMEOUT_DATA;
            mem_req_d  = 1'b0;
            state_d    = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  assign flushw = stallm;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      readdata_q  <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      readdata_q  <= readdata_d;
      mem_err_q   <= mem_err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign readdatam = readdata_q;
  assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl (TIMEOUT = 4): cycle table plus reset and back-to-back sequences.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        memtoregm, memwritem;
  logic [31:0] aluoutm, writedatam;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata, readdatam;
  logic        stallm, flushw, mem_err;

  int n_cmp = 0;
  int n_bad = 0;

  mem_access_ctrl #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .memtoregm  (memtoregm),
    .memwritem  (memwritem),
    .aluoutm    (aluoutm),
    .writedatam (writedatam),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .readdatam  (readdatam),
    .stallm     (stallm),
    .flushw     (flushw),
    .mem_err    (mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, ld, st;
    logic [31:0] addr, wd;
    logic        rdy;
    logic [31:0] rd;
    logic        e_req, e_we;
    logic [31:0] e_addr, e_wdata;
    logic        e_stall;
    logic [31:0] e_rdm;
    logic        e_err;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic ld, input logic st, input logic [31:0] addr,
                       input logic [31:0] wd, input logic rdy, input logic [31:0] rd);
    reset = rst; memtoregm = ld; memwritem = st; aluoutm = addr;
    writedatam = wd; mem_ready = rdy; mem_rdata = rd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int idx, ntx, nstall, bound;
    logic [31:0] b_addr [2];
    logic [31:0] b_data [2];
    logic adv;

    //            rst   ld    st    addr           wd             rdy   rd              req   we    maddr          mwdata         stall rdm            err
    vecs[0]  = '{1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b0,32'h0,        1'b0,1'b0,32'h0,  32'h0,        1'b0,32'h0,        1'b0};
    vecs[1]  = '{1'b0,1'b1,1'b0,32'h100,      32'h0,        1'b0,32'h0,        1'b0,1'b0,32'h0,  32'h0,        1'b1,32'h0,        1'b0};
    vecs[2]  = '{1'b0,1'b1,1'b0,32'h100,      32'h0,        1'b1,32'h12345678, 1'b1,1'b0,32'h100,32'h0,        1'b1,32'h0,        1'b0};
    vecs[3]  = '{1'b0,1'b1,1'b0,32'h100,      32'h0,        1'b0,32'h0,        1'b0,1'b0,32'h100,32'h0,        1'b0,32'h12345678, 1'b0};
    vecs[4]  = '{1'b0,1'b0,1'b1,32'h204,      32'hCAFEF00D, 1'b0,32'h0,        1'b0,1'b0,32'h100,32'h0,        1'b1,32'h12345678, 1'b0};
    vecs[5]  = '{1'b0,1'b0,1'b1,32'h204,      32'hCAFEF00D, 1'b0,32'h0,        1'b1,1'b1,32'h204,32'hCAFEF00D, 1'b1,32'h12345678, 1'b0};
    vecs[6]  = vecs[5];
    vecs[7]  = vecs[5];
    vecs[8]  = '{1'b0,1'b0,1'b1,32'h204,      32'hCAFEF00D, 1'b1,32'hFFFFFFFF, 1'b1,1'b1,32'h204,32'hCAFEF00D, 1'b1,32'h12345678, 1'b0};
    vecs[9]  = '{1'b0,1'b0,1'b1,32'h204,      32'hCAFEF00D, 1'b0,32'h0,        1'b0,1'b1,32'h204,32'hCAFEF00D, 1'b0,32'h12345678, 1'b0};
    vecs[10] = '{1'b0,1'b1,1'b0,32'h102,      32'h0,        1'b1,32'h55555555, 1'b0,1'b1,32'h204,32'hCAFEF00D, 1'b0,32'h12345678, 1'b0};
    vecs[11] = '{1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b0,32'h0,        1'b0,1'b1,32'h204,32'hCAFEF00D, 1'b0,32'h0,        1'b1};
    vecs[12] = '{1'b0,1'b1,1'b0,32'h300,      32'h0,        1'b0,32'h0,        1'b0,1'b1,32'h204,32'hCAFEF00D, 1'b1,32'h0,        1'b1};
    vecs[13] = '{1'b0,1'b1,1'b0,32'h300,      32'h0,        1'b0,32'h0,        1'b1,1'b0,32'h300,32'h0,        1'b1,32'h0,        1'b1};
    vecs[14] = vecs[13];
    vecs[15] = vecs[13];
    vecs[16] = vecs[13];
    vecs[17] = '{1'b0,1'b1,1'b0,32'h300,      32'h0,        1'b0,32'h0,        1'b0,1'b0,32'h300,32'h0,        1'b0,32'hDEADBEEF, 1'b1};
    vecs[18] = '{1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b1,32'h11111111, 1'b0,1'b0,32'h300,32'h0,        1'b0,32'hDEADBEEF, 1'b1};
    vecs[19] = '{1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b0,32'h0,        1'b0,1'b0,32'h300,32'h0,        1'b0,32'hDEADBEEF, 1'b1};

    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    next_cycle();
    next_cycle();

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].ld, vecs[i].st, vecs[i].addr, vecs[i].wd, vecs[i].rdy, vecs[i].rd);
      #3;
      chk($sformatf("row%0d_req", i),    32'(mem_req),   32'(vecs[i].e_req));
      chk($sformatf("row%0d_we", i),     32'(mem_we),    32'(vecs[i].e_we));
      chk($sformatf("row%0d_addr", i),   mem_addr,       vecs[i].e_addr);
      chk($sformatf("row%0d_wdata", i),  mem_wdata,      vecs[i].e_wdata);
      chk($sformatf("row%0d_stall", i),  32'(stallm),    32'(vecs[i].e_stall));
      chk($sformatf("row%0d_flushw", i), 32'(flushw),    32'(vecs[i].e_stall));
      chk($sformatf("row%0d_rdm", i),    readdatam,      vecs[i].e_rdm);
      chk($sformatf("row%0d_err", i),    32'(mem_err),   32'(vecs[i].e_err));
      next_cycle();
    end

    // Reset asserted in the second BUSY cycle of a load, then a clean load.
    drive(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0);
    #3; chk("rst_idle_stall", 32'(stallm), 32'd1);
    next_cycle();
    #3; chk("rst_busy1_req", 32'(mem_req), 32'd1);
    next_cycle();
    drive(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0);
    #3; chk("rst_busy2_req", 32'(mem_req), 32'd1);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #3;
    chk("rst_after_req", 32'(mem_req), 32'd0);
    chk("rst_after_stall", 32'(stallm), 32'd0);
    chk("rst_after_err", 32'(mem_err), 32'd0);
    chk("rst_after_rdm", readdatam, 32'h0);
    next_cycle();
    drive(1'b0, 1'b1, 1'b0, 32'h44, 32'h0, 1'b0, 32'h0);
    #3; chk("post_rst_stall", 32'(stallm), 32'd1);
    next_cycle();
    drive(1'b0, 1'b1, 1'b0, 32'h44, 32'h0, 1'b1, 32'h5A5A5A5A);
    #3; chk("post_rst_addr", mem_addr, 32'h44);
    next_cycle();
    drive(1'b0, 1'b1, 1'b0, 32'h44, 32'h0, 1'b0, 32'h0);
    #3;
    chk("post_rst_done_stall", 32'(stallm), 32'd0);
    chk("post_rst_rdm", readdatam, 32'h5A5A5A5A);
    next_cycle();

    // Back-to-back loads with a memory that answers in the first BUSY cycle.
    b_addr[0] = 32'h10; b_addr[1] = 32'h14;
    b_data[0] = 32'hA1A1A1A1; b_data[1] = 32'hB2B2B2B2;
    idx = 0; ntx = 0; nstall = 0; bound = 0;
    while (idx < 2 && bound < 20) begin
      drive(1'b0, 1'b1, 1'b0, b_addr[idx], 32'h0, mem_req, (ntx == 0) ? b_data[0] : b_data[1]);
      #3;
      if (mem_req && mem_ready) begin
        if (ntx < 2) chk($sformatf("b2b_tx%0d_addr", ntx), mem_addr, b_addr[ntx]);
        ntx++;
      end
      if (stallm) nstall++;
      adv = !stallm;
      if (adv) chk($sformatf("b2b_ld%0d_rdm", idx), readdatam, b_data[idx]);
      next_cycle();
      if (adv) idx++;
      bound++;
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    chk("b2b_completed", 32'(idx), 32'd2);
    chk("b2b_tx_count", 32'(ntx), 32'd2);
    chk("b2b_stall_cycles", 32'(nstall), 32'd4);
    #3;
    chk("b2b_final_rdm", readdatam, 32'hB2B2B2B2);
    chk("b2b_final_req", 32'(mem_req), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
